icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Miss handler directly upstream of the instruction cache; sits between the IRAM port and the cache write side.
- On a fetch miss it reads one cache block from IRAM as 32-bit words, one outstanding request at a time.
- It packs the words into the cache's block byte order and drives a single-cycle cache write.
- It stalls the fetch unit from miss detection until the write completes.

Parameters:
- PC_SIZE, 32, program counter / IRAM address width.
- BLOCK_SIZE, 128, cache block width in bits; multiple of INSTR_SIZE, power of two.
- INSTR_SIZE, 32, IRAM word width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- fetch_valid  in  1  fetch unit is presenting a valid pc this cycle.
- pc  in  PC_SIZE  current program counter; held stable by the fetch unit while stall=1.
- hit  in  1  cache hit signal for pc.
- stall  out  1  freeze fetch and pc.
- mem_req  out  1  IRAM read request.
- mem_addr  out  PC_SIZE  word-aligned IRAM byte address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  INSTR_SIZE  read word, little-endian.
- cache_we  out  1  one-cycle cache write strobe.
- cache_block  out  [0:BLOCK_SIZE-1]  assembled block, ascending bit numbering.

Behaviour:
- WORDS = BLOCK_SIZE/INSTR_SIZE; OFFS = log2(BLOCK_SIZE/8).
- word counter is log2(WORDS) bits wide and wraps modulo WORDS.
- States: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - miss = fetch_valid & ~hit.
  - On miss: latch base = {pc[PC_SIZE-1:OFFS], OFFS'b0}; set cnt=0; go to REQ.
  - stall = miss (combinational) in this state.
- REQ:
  - mem_req=1; mem_addr = base + 4*cnt.
  - On mem_gnt, go to WAIT; otherwise hold mem_req and mem_addr unchanged.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: store word cnt; cnt++.
  - If it was the last word, go to WRITE; otherwise go to REQ.
- WRITE:
  - cache_we=1 for exactly one cycle, then IDLE.
  - The cache indexes with pc, so pc must be unchanged since the miss. stall guarantees this.
- stall = 1 in REQ, WAIT and WRITE; it deasserts in the cycle after WRITE.
- Packing for word w:
  - cache_block[w*32+8k : w*32+8k+7] = mem_rdata[8k+7:8k], for k=0..3.
  - The least significant byte goes to the lowest ascending index.
- Latency, miss detected at cycle N, gnt immediate, rvalid one cycle after gnt:
  - REQ for word k at N+1+2k.
  - cache_we at N+9; stall low at N+10.
- Ignored inputs:
  - mem_rvalid outside WAIT, including in IDLE and REQ.
  - mem_gnt outside REQ.
  - hit and fetch_valid outside IDLE.
- No abort: a pc redirect during refill is not seen; the refill completes.
- Reset, including mid-refill:
  - state=IDLE, cnt=0, base=0, block register=0.
  - mem_req=0, cache_we=0, stall=0 (with fetch_valid=0).
  - A late rvalid after reset is dropped.
- Back-to-back misses: a miss present in the cycle after WRITE starts a new refill immediately.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - cnt starts at pc[OFFS-1:2] (the missed word) and wraps modulo WORDS.
  - Words are stored at their own index in the block.
  - A separate done-counter ends the fill after WORDS responses.
- Undefined: cnt starts at 0, fetch in ascending order.
- Output block contents are identical either way; only the IRAM request order differs.

Decomposition:
- Shared constants come from constants.sv: pc_size, instr_size, icache_blocksize; add icache_wordsperblock.
- A state enum typedef (IDLE/REQ/WAIT/WRITE) belongs in the shared package for reuse by the data-side refill.
- Sub-module icache_word_pack:
  - Combinational byte-lane swap plus indexed write into the block register.
  - Instantiated once; worth isolating because the data cache reuses it.

Test Plan:
1. Reset, then fetch_valid=1, hit=0, pc=0x0000_0104:
   - mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
   - rdata 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00.
   - cache_we at N+9; cache_block[0:7]=0x44, cache_block[24:31]=0x11, cache_block[96:103]=0x00.
2. mem_gnt held low 5 cycles in REQ:
   - mem_req and mem_addr=0x100 stable throughout.
   - stall=1 throughout; cache_we delayed by 5 cycles.
3. Spurious mem_rvalid in IDLE and in REQ:
   - No state change, no cache_we, block register unchanged.
4. rst asserted in WAIT of word 2:
   - Next cycle IDLE, stall=0, mem_req=0.
   - A following rvalid is ignored; the next miss refetches from word 0.
5. With ICACHE_CRITICAL_WORD_FIRST_EN, pc=0x0000_0208:
   - Address order 0x208, 0x20C, 0x200, 0x204.
   - Block identical to the ascending-order result for the same data.
6. hit=1 with fetch_valid=1 for 20 cycles:
   - stall=0, mem_req=0, cache_we=0 throughout.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared constants and refill FSM state type for the cache miss handlers
package icache_refill_ctrl_pkg;

  localparam int pc_size              = 32;
  localparam int instr_size           = 32;
  localparam int icache_blocksize     = 128;
  localparam int icache_wordsperblock = icache_blocksize / instr_size;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE
  } refill_state_e;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - IRAM read port and cache write port of the refill controller
interface icache_refill_ctrl_if #(
  parameter int PC_SIZE    = icache_refill_ctrl_pkg::pc_size,
  parameter int BLOCK_SIZE = icache_refill_ctrl_pkg::icache_blocksize,
  parameter int INSTR_SIZE = icache_refill_ctrl_pkg::instr_size
);

  logic                  mem_req;
  logic [PC_SIZE-1:0]    mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [INSTR_SIZE-1:0] mem_rdata;
  logic                  cache_we;
  logic [0:BLOCK_SIZE-1] cache_block;

  modport master (
    output mem_req, mem_addr, cache_we, cache_block,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, cache_we, cache_block,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/icache_word_pack.sv
// rtl/icache_word_pack.sv - places one little-endian IRAM word into an ascending-numbered cache block
module icache_word_pack #(
  parameter int BLOCK_SIZE = 128,
  parameter int INSTR_SIZE = 32,
  parameter int IDX_W      = 2
) (
  input  logic [0:BLOCK_SIZE-1] block_in,
  input  logic [IDX_W-1:0]      idx,
  input  logic [INSTR_SIZE-1:0] word,
  output logic [0:BLOCK_SIZE-1] block_out
);

  // Byte k of the word lands at ascending offset 8k inside its word slot,
  // so the least significant byte sits at the lowest block index.
  always_comb begin
    block_out = block_in;
    for (int k = 0; k < INSTR_SIZE / 8; k++) begin
      block_out[int'(idx) * INSTR_SIZE + 8 * k +: 8] = word[8 * k +: 8];
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache miss handler: fetches one block from IRAM, writes it to the cache
// Optional ICACHE_CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int PC_SIZE    = pc_size,
  parameter int BLOCK_SIZE = icache_blocksize,
  parameter int INSTR_SIZE = instr_size
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic [PC_SIZE-1:0]   pc,
  input  logic                 hit,
  output logic                 stall,
  icache_refill_ctrl_if.master bus
);

  localparam int WORDS = BLOCK_SIZE / INSTR_SIZE;
  localparam int OFFS  = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_W = clog2_min1(WORDS);

  refill_state_e         state;
  refill_state_e         state_next;
  logic [CNT_W-1:0]      cnt;
  logic [PC_SIZE-1:0]    base;
  logic [0:BLOCK_SIZE-1] block;
  logic [0:BLOCK_SIZE-1] block_packed;
  logic                  miss;
  logic                  take_word;
  logic                  last_word;
  logic                  unused_pc_bits;

  assign miss           = fetch_valid & ~hit;
  assign take_word      = (state == WAIT) & bus.mem_rvalid;
  assign unused_pc_bits = ^pc[OFFS-1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  // cnt wraps from the missed word, so completion is tracked separately.
  logic [CNT_W-1:0] done_cnt;
  assign last_word = (done_cnt == CNT_W'(WORDS - 1));
`else
  assign last_word = (cnt == CNT_W'(WORDS - 1));
`endif

  icache_word_pack #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .INSTR_SIZE (INSTR_SIZE),
    .IDX_W      (CNT_W)
  ) u_word_pack (
    .block_in  (block),
    .idx       (cnt),
    .word      (bus.mem_rdata),
    .block_out (block_packed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      block <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      done_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      if ((state == IDLE) && miss) begin
        base <= {pc[PC_SIZE-1:OFFS], {OFFS{1'b0}}};
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        cnt      <= pc[OFFS-1 -: CNT_W];
        done_cnt <= '0;
`else
        cnt <= '0;
`endif
      end else if (take_word) begin
        block <= block_packed;
        cnt   <= cnt + CNT_W'(1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        done_cnt <= done_cnt + CNT_W'(1);
`endif
      end
    end
  end

  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    bus.mem_req  = 1'b0;
    bus.cache_we = 1'b0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) state_next = REQ;
      end
      REQ: begin
        stall       = 1'b1;
        bus.mem_req = 1'b1;
        if (bus.mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.mem_rvalid) state_next = last_word ? WRITE : REQ;
      end
      WRITE: begin
        stall        = 1'b1;
        bus.cache_we = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_addr    = base + (PC_SIZE'(cnt) << 2);
  assign bus.cache_block = block;

endmodule
